opamp_sd_adc_ctrl: RTL and testbench

Digital half of a first-order delta-sigma ADC wrapped around the on-chip opamp, which is configured as integrator plus comparator. The block synchronises the comparator decision, drives the 1-bit feedback DAC pin that closes the loop back into the opamp, and decimates the bitstream into an unsigned result by counting ones over a power-of-two window. It sits directly downstream of the opamp (comparator in) and upstream of it (feedback out), with results presented on dedicated outputs.

---
 rtl/opamp_sd_adc_ctrl_pkg.sv | 27 ++
 rtl/opamp_sd_adc_ctrl_if.sv | 29 ++
 rtl/opamp_sd_adc_ctrl_sync_2ff.sv | 19 +
 rtl/opamp_sd_adc_ctrl.sv | 111 +++++++++++
 tb/tb_opamp_sd_adc_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/opamp_sd_adc_ctrl_pkg.sv
// Shared types, default parameters and the result scaling helper for the
// opamp delta-sigma ADC controller.
package opamp_adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CONVERT = 2'd2
  } adc_state_e;

  localparam int DEF_OSR_LOG2   = 8;
  localparam int DEF_RESULT_W   = 8;
  localparam int DEF_SETTLE_CYC = 16;

  // A window of all ones counts 2^osr_log2, one past full scale, so clamp it
  // before keeping the top result_w bits.
  function automatic logic [31:0] sat_trunc(input logic [31:0] ones,
                                            input int osr_log2,
                                            input int result_w);
    logic [31:0] max_v;
    logic [31:0] sat;
    max_v = (32'd1 << osr_log2) - 32'd1;
    sat   = (ones > max_v) ? max_v : ones;
    return sat >> (osr_log2 - result_w);
  endfunction

endpackage

// File: rtl/opamp_sd_adc_ctrl_if.sv
// Control/result bundle between the ADC controller and its host and opamp.
interface opamp_sd_adc_ctrl_if
  import opamp_adc_pkg::*;
#(
  parameter int RESULT_W = DEF_RESULT_W
);
  // No valid/ready pair here: start is a level sampled only in IDLE, and
  // result_valid is a one-cycle strobe with no backpressure; result holds
  // its value until the next strobe.
  logic                ena;
  logic                start;
  logic                continuous;
  logic                comp_in;
  logic                fb_out;
  logic                busy;
  logic [RESULT_W-1:0] result;
  logic                result_valid;
  adc_state_e          state_dbg;

  modport master (
    output ena, start, continuous, comp_in,
    input  fb_out, busy, result, result_valid, state_dbg
  );

  modport slave (
    input  ena, start, continuous, comp_in,
    output fb_out, busy, result, result_valid, state_dbg
  );
endinterface

// File: rtl/opamp_sd_adc_ctrl_sync_2ff.sv
// Two-flop synchroniser for the asynchronous comparator decision.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end
endmodule

// File: rtl/opamp_sd_adc_ctrl.sv
// First-order delta-sigma loop controller: drives the feedback DAC bit from
// the synchronised comparator and decimates the bitstream by counting ones.
module opamp_sd_adc_ctrl
  import opamp_adc_pkg::*;
#(
  parameter int OSR_LOG2   = DEF_OSR_LOG2,
  parameter int RESULT_W   = DEF_RESULT_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input logic               clk,
  input logic               rst_n,
  opamp_sd_adc_ctrl_if.slave bus
);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0]       SETTLE_LOAD = SW'(SETTLE_CYC - 1);
  localparam logic [OSR_LOG2-1:0] SAMPLE_LAST = '1;

  adc_state_e          state_q, state_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [OSR_LOG2-1:0] sample_q, sample_d;
  logic [OSR_LOG2:0]   ones_q, ones_d, ones_sum;
  logic                fb_q, fb_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic                rv_q, rv_d;
  logic                comp_s;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.comp_in),
    .q     (comp_s)
  );

  // The sample on the closing cycle is still the registered feedback bit,
  // so it is folded into the sum before the result is formed.
  assign ones_sum = ones_q + (OSR_LOG2 + 1)'(fb_q);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    sample_d = sample_q;
    ones_d   = ones_q;
    fb_d     = 1'b0;
    result_d = result_q;
    rv_d     = 1'b0;
    if (!bus.ena) begin
      state_d  = IDLE;
      settle_d = '0;
      sample_d = '0;
      ones_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d  = SETTLE;
            settle_d = SETTLE_LOAD;
          end
        end
        SETTLE: begin
          fb_d = comp_s;
          if (settle_q == '0) begin
            state_d  = CONVERT;
            sample_d = '0;
            ones_d   = '0;
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end
        CONVERT: begin
          fb_d     = comp_s;
          sample_d = sample_q + 1'b1;
          ones_d   = ones_sum;
          if (sample_q == SAMPLE_LAST) begin
            result_d = RESULT_W'(sat_trunc(32'(ones_sum), OSR_LOG2, RESULT_W));
            rv_d     = 1'b1;
            sample_d = '0;
            ones_d   = '0;
            if (!bus.continuous) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      sample_q <= '0;
      ones_q   <= '0;
      fb_q     <= 1'b0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      sample_q <= sample_d;
      ones_q   <= ones_d;
      fb_q     <= fb_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  assign bus.fb_out       = fb_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_opamp_sd_adc_ctrl.sv
// Directed bench for opamp_sd_adc_ctrl with a cycle-offset reference model
// checked against every output on every cycle.
module tb_opamp_sd_adc_ctrl;
  import opamp_adc_pkg::*;

  localparam int SETTLE = 16;
  localparam int WIN    = 256;
  localparam int LAT    = SETTLE + WIN;

  logic clk;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;
  int   comp_mode = 0;

  opamp_sd_adc_ctrl_if #(.RESULT_W(8)) bus ();

  opamp_sd_adc_ctrl #(
    .OSR_LOG2   (8),
    .RESULT_W   (8),
    .SETTLE_CYC (SETTLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // ---------------- comparator pattern driver ----------------
  initial begin : comp_drv
    int ph;
    ph = 0;
    bus.comp_in = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      ph++;
      case (comp_mode)
        0: bus.comp_in = 1'b0;
        1: bus.comp_in = 1'b1;
        2: bus.comp_in = ph[0];
        default: bus.comp_in = ((ph % 4) == 0);
      endcase
    end
  end

  // ---------------- reference model + compare ----------------
  // Expected behaviour is expressed as offsets from the start edge e0:
  // busy for edges e0+1 .. e0+272, window = feedback bits present in the
  // 256 cycles before the closing edge, feedback = comparator two edges ago.
  logic hist[int];
  int   e      = 0;
  int   e0     = 0;
  bit   active = 0;
  int   win    = 0;
  int   busy_m = 0;
  int   fb_m   = 0;
  int   res_m  = 0;
  int   rv_m   = 0;

  function automatic int model_sat(input int ones);
    return (ones > 255) ? 255 : ones;
  endfunction

  task automatic model_step();
    int prev_busy;
    int nfb;
    int t;
    e++;
    hist[e] = rst_n ? bus.comp_in : 1'b0;
    if (!rst_n) begin
      active = 0; win = 0; busy_m = 0; fb_m = 0; res_m = 0; rv_m = 0;
      return;
    end
    prev_busy = busy_m;
    nfb = (bus.ena && prev_busy != 0 && e > 2) ? int'(hist[e-2]) : 0;
    rv_m = 0;
    if (!bus.ena) begin
      active = 0; busy_m = 0; win = 0;
    end else if (!active) begin
      if (bus.start) begin
        active = 1; e0 = e; busy_m = 1; win = 0;
      end
    end else begin
      t = e - e0;
      if (t > SETTLE) win += fb_m;
      if (t >= LAT && ((t - SETTLE) % WIN) == 0) begin
        res_m = model_sat(win);
        rv_m  = 1;
        win   = 0;
        if (!bus.continuous) begin
          active = 0; busy_m = 0;
        end
      end
    end
    fb_m = nfb;
  endtask

  initial begin : compare
    forever begin
      @(posedge clk);
      #1;
      model_step();
      check("cyc_fb_out", int'(bus.fb_out), fb_m);
      check("cyc_busy", int'(bus.busy), busy_m);
      check("cyc_result", int'(bus.result), res_m);
      check("cyc_result_valid", int'(bus.result_valid), rv_m);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk); #2;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic run_single(input int mode, input int exp_res, input string name);
    int got;
    @(posedge clk); #2;
    comp_mode = mode;
    repeat (4) @(posedge clk);
    pulse_start();
    got = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (bus.result_valid) begin
        got = k;
        break;
      end
    end
    check({name, "_latency"}, got, LAT);
    check({name, "_result"}, int'(bus.result), exp_res);
    check({name, "_busy_after"}, int'(bus.busy), 0);
    @(posedge clk); #1;
    check({name, "_valid_once"}, int'(bus.result_valid), 0);
  endtask

  task automatic run_continuous();
    int last_k;
    int pulses;
    int busy_low;
    int k;
    @(posedge clk); #2;
    comp_mode = 1;
    bus.continuous = 1'b1;
    repeat (4) @(posedge clk);
    pulse_start();
    last_k = 0; pulses = 0; busy_low = 0; k = 0;
    while (pulses < 3 && k < 1200) begin
      @(posedge clk); #1;
      k++;
      if (!bus.busy) busy_low++;
      if (bus.result_valid) begin
        check("cont_gap", k - last_k, (pulses == 0) ? LAT : WIN);
        check("cont_result", int'(bus.result), 255);
        last_k = k;
        pulses++;
      end
    end
    check("cont_pulses", pulses, 3);
    check("cont_busy_high", busy_low, 0);
    #1;
    bus.continuous = 1'b0;
    pulses = 0;
    for (int j = 1; j <= 300; j++) begin
      @(posedge clk); #1;
      if (bus.result_valid) begin
        check("cont_last_gap", j, WIN - 0);
        pulses = 1;
        break;
      end
    end
    check("cont_last_seen", pulses, 1);
    check("cont_busy_after_stop", int'(bus.busy), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int rv_seen;
    rst_n          = 1'b0;
    bus.ena        = 1'b1;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fb_out", int'(bus.fb_out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_result", int'(bus.result), 0);
    check("rst_result_valid", int'(bus.result_valid), 0);
    #1;
    rst_n = 1'b1;

    run_single(1, 8'hFF, "ones");
    run_single(0, 8'h00, "zeros");
    run_single(2, 8'h80, "toggle");
    run_single(3, 8'h40, "quarter");
    run_continuous();

    // reset 100 cycles into CONVERT
    @(posedge clk); #2;
    comp_mode = 1;
    repeat (4) @(posedge clk);
    pulse_start();
    repeat (SETTLE + 100) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_fb_out", int'(bus.fb_out), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_result", int'(bus.result), 0);
    check("midrst_result_valid", int'(bus.result_valid), 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_single(1, 8'hFF, "after_rst");

    // ena dropped mid-window keeps the previous result
    run_single(2, 8'h80, "pre_ena");
    @(posedge clk); #2;
    comp_mode = 1;
    repeat (4) @(posedge clk);
    pulse_start();
    repeat (SETTLE + 50) @(posedge clk);
    #2;
    bus.ena = 1'b0;
    @(posedge clk); #1;
    check("ena_drop_busy", int'(bus.busy), 0);
    check("ena_drop_fb_out", int'(bus.fb_out), 0);
    check("ena_drop_result", int'(bus.result), 8'h80);
    rv_seen = 0;
    for (int j = 0; j < 300; j++) begin
      @(posedge clk); #1;
      if (bus.result_valid) rv_seen++;
    end
    check("ena_drop_no_valid", rv_seen, 0);
    #1;
    bus.ena = 1'b1;

    // comparator step in IDLE, observed on fb_out during SETTLE
    @(posedge clk); #2;
    comp_mode = 0;
    repeat (6) @(posedge clk);
    #2;
    comp_mode = 1;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("step_fb_edge2", int'(bus.fb_out), 0);
    @(posedge clk); #1;
    check("step_fb_edge3", int'(bus.fb_out), 1);
    rv_seen = 0;
    for (int j = 0; j < 300; j++) begin
      @(posedge clk); #1;
      if (bus.result_valid) begin
        rv_seen = 1;
        check("step_result", int'(bus.result), 8'hFF);
        break;
      end
    end
    check("step_done", rv_seen, 1);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
